// File: rtl/alg_unit_if.sv
// EX-stage handshake between the pipeline and the multi-cycle multiply/divide engine.
// The master side is the EX stage; the slave side is the engine.
interface alg_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op_x_bits;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;

  modport master (
    output start, op_x_bits, opA, opB, flush,
    input  stall, done, res_lo, res_hi
  );

  modport slave (
    input  start, op_x_bits, opA, opB, flush,
    output stall, done, res_lo, res_hi
  );
endinterface

// File: rtl/alg_unit.sv
// Multi-cycle unsigned multiply (shift-add, LSB first) and restoring divide (MSB first).
// Both result halves are held until the next completed mul/div.
module alg_unit #(
  parameter int         WIDTH  = 16,
  parameter logic [2:0] OP_MUL = 3'b011,
  parameter logic [2:0] OP_DIV = 3'b101
) (
  input  logic       clk,
  input  logic       reset_n,
  alg_unit_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   opa_q;   // multiplicand / dividend shifting into quotient
  logic [WIDTH-1:0]   opb_q;   // multiplier shifting right / divisor
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   res_lo_q;
  logic [WIDTH-1:0]   res_hi_q;

  logic is_mul, is_div, div_zero, last;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH:0]     rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  assign is_mul   = bus.start && (bus.op_x_bits == OP_MUL);
  assign is_div   = bus.start && (bus.op_x_bits == OP_DIV);
  assign div_zero = (bus.opB == '0);
  assign last     = (count == LAST);

  // Datapath step for one iteration of either operation
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opb_q[0] ? opa_q : '0)};
    acc_nx    = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {rem[WIDTH-1:0], opa_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    div_ok    = ~div_diff[WIDTH+1];
    rem_nx    = div_ok ? div_diff[WIDTH:0] : div_shift;
    quo_nx    = {opa_q[WIDTH-2:0], div_ok};
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (is_mul)      state_nx = MUL;
        else if (is_div) state_nx = div_zero ? DONE : DIV;
      end
      MUL:     if (last) state_nx = DONE;
      DIV:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  // Outputs
  always_comb begin
    bus.stall = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE:    bus.stall = is_mul | is_div;
      MUL:     bus.stall = 1'b1;
      DIV:     bus.stall = 1'b1;
      DONE:    bus.done  = 1'b1;
      default: ;
    endcase
  end

  assign bus.res_lo = res_lo_q;
  assign bus.res_hi = res_hi_q;

  // Operand, accumulator and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc      <= '0;
      rem      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            opa_q <= bus.opA;
            opb_q <= bus.opB;
            acc   <= '0;
            count <= '0;
          end else if (is_div) begin
            if (div_zero) begin
              res_lo_q <= '1;
              res_hi_q <= bus.opA;
            end else begin
              opa_q <= bus.opA;
              opb_q <= bus.opB;
              rem   <= '0;
              count <= '0;
            end
          end
        end
        MUL: begin
          acc   <= acc_nx;
          opb_q <= opb_q >> 1;
          count <= count + 1'b1;
          if (last) begin
            res_hi_q <= acc_nx[2*WIDTH-1:WIDTH];
            res_lo_q <= acc_nx[WIDTH-1:0];
            count    <= '0;
          end
        end
        DIV: begin
          rem   <= rem_nx;
          opa_q <= quo_nx;
          count <= count + 1'b1;
          if (last) begin
            res_lo_q <= quo_nx;
            res_hi_q <= rem_nx[WIDTH-1:0];
            count    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
